mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the fetch stage (IF) and the data-access stage (DM) of the five-stage RV32I pipeline. It registers one transaction at a time, drives a valid/ready handshake to memory, returns read data with a one-cycle done pulse, and produces per-stage stall signals for the hazard logic. DM normally has priority; a streak counter guarantees IF forward progress. A kill input drops the result of an in-flight fetch on a branch flush.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width
MAX_DM_STREAK, 4, maximum consecutive DM grants while IF is waiting; range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  ADDR_W  fetch address
if_kill  in  1  discard the pending or in-flight fetch result (branch flush)
if_rdata  out  DATA_W  fetched instruction; valid when if_done
if_done  out  1  one-cycle completion pulse for IF
dm_req  in  1  data request; held high until dm_done
dm_we  in  1  1 = store, 0 = load
dm_size  in  3  DatasizeSel encoding, passed through unchanged
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data; valid when dm_done
dm_done  out  1  one-cycle completion pulse for DM
mem_req  out  1  memory request valid
mem_we  out  1  memory write enable
mem_size  out  3  access size
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid with mem_ready
mem_ready  in  1  memory accepts and completes the request this cycle
stall_if  out  1  = if_req & ~if_done (combinational)
stall_mem  out  1  = dm_req & ~dm_done (combinational)

Behaviour:
- Reset values: state IDLE, mem_req/mem_we 0, mem_addr/mem_wdata/mem_size 0, if_done/dm_done 0, if_rdata/dm_rdata 0, streak 0, kill_pend 0.
- FSM states are IDLE, BUSY_IF and BUSY_DM.
- IDLE → arbitration:
  - A port's request is ignored in any cycle in which its own done is high.
  - If both ports request and streak == MAX_DM_STREAK, grant IF. Otherwise, if dm_req is high, grant DM. Otherwise, if if_req is high, grant IF.
  - On grant, register the address, write enable, size and write data into the mem_* outputs, set mem_req = 1, and move to the matching BUSY state.
  - An IF grant always drives mem_we = 0 and mem_size = 3'b010 (word).
- BUSY_x: mem_* outputs stay stable while mem_req=1 and mem_ready=0. The transfer completes on the rising edge where mem_req & mem_ready. At that edge:
  - mem_req clears.
  - mem_rdata is captured into x_rdata.
  - x_done is asserted for exactly the next cycle.
  - The state returns to IDLE.
- Latency: a request arriving in cycle 0 gives mem_req in cycle 1; with mem_ready in cycle 1, done is high in cycle 2. The minimum is 2 cycles, and each mem_ready wait cycle adds 1. Throughput is at most one transfer per 2 cycles.
- Stores: dm_done pulses exactly as for loads; dm_rdata is updated with mem_rdata (don't-care content).
- Streak counter (4 bits):
  - +1 on each DM grant while if_req is high; saturates at MAX_DM_STREAK.
  - Clears to 0 on an IF grant or whenever if_req is low.
- if_kill:
  - In IDLE, or in BUSY_DM with an IF request pending: the pending fetch is not granted this cycle.
  - In BUSY_IF: sets kill_pend. The memory transaction still completes with the handshake intact, if_done is suppressed and if_rdata is not updated. kill_pend clears on completion.
- Simultaneous events:
  - if_kill in the completion cycle of a fetch suppresses that fetch's if_done.
  - A new request arriving in the same cycle as completion is arbitrated from IDLE in the following cycle.
- Request withdrawn while BUSY: the transaction still completes; the done pulse is still issued.
- rst asserted mid-transaction: all state returns to reset values at the next edge; mem_req drops; no done pulse. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state enum IDLE/BUSY_IF/BUSY_DM
  - SIZE_WORD = 3'b010
  - grant-source encoding GNT_IF/GNT_DM
- One sub-module, `mem_arb_streak`: saturating streak counter with inputs inc, clr and at_max.
- FSM, output registers and the kill logic stay in the top module.

Test Plan:
1. Basic fetch: rst, then if_req=1, if_addr=0x10, with mem_ready=1 and mem_rdata=0x00500093. Expect mem_req high in cycle 1 with mem_addr=0x10 and mem_we=0; if_done in cycle 2 with if_rdata=0x00500093; stall_if high in cycles 0–1.
2. Wait states: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, dm_size=3'b010, with mem_ready held low for 3 cycles. Expect mem_* stable for 4 cycles, a single dm_done, and stall_mem high throughout.
3. Priority and starvation: if_req and dm_req held continuously with mem_ready=1 (MAX_DM_STREAK=4). Expect the grant order DM, DM, DM, DM, IF, then DM resumes.
4. Kill in flight: fetch granted to 0x20, if_kill pulsed while mem_ready=0, then mem_ready=1. Expect the memory handshake to complete, no if_done, and if_rdata unchanged.
5. Reset mid-transaction: DM store in BUSY_DM with mem_ready=0, then rst=1 for one cycle. Expect mem_req=0, dm_done=0, streak=0 and state IDLE on the next edge.
6. Back-to-back: DM load completes (dm_done cycle) while if_req is high. Expect IF mem_req in the cycle after dm_done; IF must not be granted during the dm_done cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter.
// State, grant source and access-size constants.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_src_e;

    localparam logic [2:0] SIZE_WORD = 3'b010;
    localparam int         STREAK_W  = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF port, DM port and memory bus.
// master = arbiter side, slave = pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              dm_req;
    logic              dm_we;
    logic [2:0]        dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall_if;
    logic              stall_mem;

    modport master (
        input  if_req, if_addr, if_kill,
        input  dm_req, dm_we, dm_size,
        input  dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_done,
        output dm_rdata, dm_done,
        output mem_req, mem_we, mem_size,
        output mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport slave (
        output if_req, if_addr, if_kill,
        output dm_req, dm_we, dm_size,
        output dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_done,
        input  dm_rdata, dm_done,
        input  mem_req, mem_we, mem_size,
        input  mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_arb_streak.sv
// Saturating count of DM grants won while IF waits.
// at_max tells the arbiter to hand the next slot to IF.
module mem_arb_streak
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX);

    logic [STREAK_W-1:0] cnt_q;
    logic [STREAK_W-1:0] cnt_d;

    // clear wins; increment stops at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // streak register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by fetch and data stages.
// One registered transaction at a time, DM first, IF anti-starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.master bus
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [2:0]        mem_size_q, mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              kill_pend_q, kill_pend_d;

    logic     if_req_eff;
    logic     dm_req_eff;
    logic     gnt_vld;
    gnt_src_e gnt_src;
    logic     xfer;
    logic     at_max;
    logic     streak_inc;
    logic     streak_clr;

    // pick a winner while idle; a port's own done masks it
    always_comb begin
        if_req_eff = bus.if_req & ~if_done_q & ~bus.if_kill;
        dm_req_eff = bus.dm_req & ~dm_done_q;
        gnt_vld    = 1'b0;
        gnt_src    = GNT_DM;
        if (state_q == IDLE) begin
            if (if_req_eff && dm_req_eff && at_max) begin
                gnt_vld = 1'b1;
                gnt_src = GNT_IF;
            end else if (dm_req_eff) begin
                gnt_vld = 1'b1;
                gnt_src = GNT_DM;
            end else if (if_req_eff) begin
                gnt_vld = 1'b1;
                gnt_src = GNT_IF;
            end
        end
        streak_inc = gnt_vld & (gnt_src == GNT_DM) & bus.if_req;
        streak_clr = ~bus.if_req
                   | (gnt_vld & (gnt_src == GNT_IF));
    end

    mem_arb_streak #(
        .MAX (MAX_DM_STREAK)
    ) u_streak (
        .clk    (clk),
        .rst    (rst),
        .inc    (streak_inc),
        .clr    (streak_clr),
        .at_max (at_max)
    );

    // next state, bus launch, completion and kill tracking
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        kill_pend_d = kill_pend_q;
        xfer        = mem_req_q & bus.mem_ready;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    mem_req_d = 1'b1;
                    if (gnt_src == GNT_IF) begin
                        mem_we_d    = 1'b0;
                        mem_size_d  = SIZE_WORD;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        state_d     = BUSY_IF;
                    end else begin
                        mem_we_d    = bus.dm_we;
                        mem_size_d  = bus.dm_size;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        state_d     = BUSY_DM;
                    end
                end
            end
            BUSY_IF: begin
                if (bus.if_kill) begin
                    kill_pend_d = 1'b1;
                end
                if (xfer) begin
                    mem_req_d   = 1'b0;
                    kill_pend_d = 1'b0;
                    state_d     = IDLE;
                    if (!(kill_pend_q || bus.if_kill)) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            BUSY_DM: begin
                if (xfer) begin
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            kill_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            kill_pend_q <= kill_pend_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = bus.dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model
// checked every cycle plus directed literal expectations.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .MAX_DM_STREAK (MAXS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // transaction-level model of the arbiter
    bit          m_req = 0;
    bit          m_src_if = 0;
    logic [31:0] m_addr = 0;
    bit          m_we = 0;
    logic [2:0]  m_size = 0;
    logic [31:0] m_wdata = 0;
    bit          m_if_done = 0;
    bit          m_dm_done = 0;
    logic [31:0] m_if_rdata = 0;
    logic [31:0] m_dm_rdata = 0;
    bit          m_killp = 0;
    int          m_streak = 0;

    always @(posedge clk) begin
        bit ir, dr, gi, gd, nid, ndd;
        if (rst) begin
            m_req = 0; m_we = 0; m_size = 0;
            m_addr = 0; m_wdata = 0;
            m_if_done = 0; m_dm_done = 0;
            m_if_rdata = 0; m_dm_rdata = 0;
            m_killp = 0; m_streak = 0;
        end else begin
            ir = bus.if_req && !m_if_done && !bus.if_kill;
            dr = bus.dm_req && !m_dm_done;
            gi = 0; gd = 0; nid = 0; ndd = 0;
            if (m_req) begin
                if (m_src_if && bus.if_kill) m_killp = 1;
                if (bus.mem_ready) begin
                    if (m_src_if) begin
                        if (!m_killp) begin
                            nid = 1;
                            m_if_rdata = bus.mem_rdata;
                        end
                    end else begin
                        ndd = 1;
                        m_dm_rdata = bus.mem_rdata;
                    end
                    m_req = 0;
                    m_killp = 0;
                end
            end else begin
                if (ir && dr && m_streak == MAXS) gi = 1;
                else if (dr) gd = 1;
                else if (ir) gi = 1;
                if (gi) begin
                    m_req = 1; m_src_if = 1;
                    m_addr = bus.if_addr;
                    m_we = 0; m_size = 3'b010;
                end
                if (gd) begin
                    m_req = 1; m_src_if = 0;
                    m_addr = bus.dm_addr;
                    m_we = bus.dm_we;
                    m_size = bus.dm_size;
                    m_wdata = bus.dm_wdata;
                end
            end
            if (!bus.if_req || gi) m_streak = 0;
            else if (gd && m_streak < MAXS) m_streak++;
            m_if_done = nid;
            m_dm_done = ndd;
        end
    end

    // every-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        chk("mdl_mem_req", bus.mem_req, m_req);
        if (m_req) begin
            chk("mdl_mem_addr", bus.mem_addr, m_addr);
            chk("mdl_mem_we", bus.mem_we, m_we);
            chk("mdl_mem_size", bus.mem_size, m_size);
            if (!m_src_if)
                chk("mdl_mem_wdata", bus.mem_wdata, m_wdata);
        end
        chk("mdl_if_done", bus.if_done, m_if_done);
        chk("mdl_dm_done", bus.dm_done, m_dm_done);
        chk("mdl_if_rdata", bus.if_rdata, m_if_rdata);
        chk("mdl_dm_rdata", bus.dm_rdata, m_dm_rdata);
        chk("mdl_stall_if", bus.stall_if,
            bus.if_req && !m_if_done);
        chk("mdl_stall_mem", bus.stall_mem,
            bus.dm_req && !m_dm_done);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int gr [6];
    int expg [6] = '{1, 1, 1, 1, 0, 1};
    int ng;

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_size = 0;
        bus.dm_addr = 0; bus.dm_wdata = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;
        do_reset();

        // reset state
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_size", bus.mem_size, 0);
        chk("rst_if_done", bus.if_done, 0);
        chk("rst_dm_done", bus.dm_done, 0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));

        // 1: basic fetch
        bus.if_req = 1; bus.if_addr = 32'h10;
        bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
        #1 chk("t1_stall_c0", bus.stall_if, 1);
        tick();
        chk("t1_mem_req_c1", bus.mem_req, 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        chk("t1_mem_we", bus.mem_we, 0);
        chk("t1_stall_c1", bus.stall_if, 1);
        tick();
        chk("t1_if_done_c2", bus.if_done, 1);
        chk("t1_if_rdata", bus.if_rdata, 32'h00500093);
        chk("t1_stall_c2", bus.stall_if, 0);
        chk("t1_mem_req_c2", bus.mem_req, 0);
        bus.if_req = 0;
        tick();

        // 2: store with wait states
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40;
        bus.dm_wdata = 32'hDEADBEEF; bus.dm_size = 3'b010;
        bus.mem_ready = 0; bus.mem_rdata = 32'h0BADF00D;
        #1 chk("t2_stall_c0", bus.stall_mem, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t2_req_c%0d", k), bus.mem_req, 1);
            chk($sformatf("t2_addr_c%0d", k), bus.mem_addr, 32'h40);
            chk($sformatf("t2_we_c%0d", k), bus.mem_we, 1);
            chk($sformatf("t2_wd_c%0d", k), bus.mem_wdata,
                32'hDEADBEEF);
            chk($sformatf("t2_done_c%0d", k), bus.dm_done, 0);
            chk($sformatf("t2_stall_c%0d", k), bus.stall_mem, 1);
            if (k == 4) bus.mem_ready = 1;
        end
        tick();
        chk("t2_dm_done", bus.dm_done, 1);
        chk("t2_stall_done", bus.stall_mem, 0);
        bus.dm_req = 0; bus.mem_ready = 0;
        tick();
        chk("t2_dm_done_once", bus.dm_done, 0);
        chk("t2_mem_req_off", bus.mem_req, 0);

        // 3: DM priority and IF anti-starvation
        do_reset();
        bus.if_addr = 32'h100; bus.dm_addr = 32'h80;
        bus.dm_we = 0; bus.mem_ready = 1;
        bus.mem_rdata = 32'h5A5A5A5A;
        bus.if_req = 1; bus.dm_req = 1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            tick();
            bus.if_kill = bus.dm_done;
            if (bus.mem_req) begin
                gr[ng] = (bus.mem_addr == 32'h100) ? 0 : 1;
                ng++;
            end
        end
        bus.if_req = 0; bus.dm_req = 0; bus.if_kill = 0;
        chk("t3_ngrants", ng, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_grant%0d_dm", i), gr[i], expg[i]);
        tick();
        tick();

        // 4: kill of an in-flight fetch
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h1C;
        bus.mem_ready = 1; bus.mem_rdata = 32'h11111111;
        tick();
        tick();
        chk("t4_prev_rdata", bus.if_rdata, 32'h11111111);
        bus.if_req = 0;
        tick();
        bus.if_req = 1; bus.if_addr = 32'h20;
        bus.mem_ready = 0; bus.mem_rdata = 32'hAAAA0000;
        tick();
        chk("t4_mem_req", bus.mem_req, 1);
        chk("t4_mem_addr", bus.mem_addr, 32'h20);
        bus.if_kill = 1; bus.if_req = 0;
        tick();
        bus.if_kill = 0;
        chk("t4_req_held", bus.mem_req, 1);
        bus.mem_ready = 1;
        tick();
        chk("t4_hs_done", bus.mem_req, 0);
        chk("t4_no_done_a", bus.if_done, 0);
        tick();
        chk("t4_no_done_b", bus.if_done, 0);
        chk("t4_rdata_kept", bus.if_rdata, 32'h11111111);
        bus.mem_ready = 0;

        // 5: reset in the middle of a store
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h24;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h44;
        bus.dm_wdata = 32'hCAFEF00D; bus.mem_ready = 0;
        tick();
        chk("t5_mem_req", bus.mem_req, 1);
        chk("t5_mem_addr", bus.mem_addr, 32'h44);
        chk("t5_streak_pre", 32'(dut.u_streak.cnt_q), 1);
        rst = 1;
        tick();
        chk("t5_mem_req_rst", bus.mem_req, 0);
        chk("t5_dm_done_rst", bus.dm_done, 0);
        chk("t5_streak_rst", 32'(dut.u_streak.cnt_q), 0);
        chk("t5_state_rst", 32'(dut.state_q), 32'(IDLE));
        rst = 0; bus.dm_req = 0; bus.if_req = 0;
        tick();
        chk("t5_no_done", bus.dm_done, 0);

        // 6: DM load then IF back-to-back
        do_reset();
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h60;
        bus.dm_size = 3'b000;
        bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
        tick();
        chk("t6_dm_req_c1", bus.mem_req, 1);
        bus.if_req = 1; bus.if_addr = 32'h30;
        tick();
        chk("t6_dm_done", bus.dm_done, 1);
        chk("t6_dm_rdata", bus.dm_rdata, 32'h12345678);
        chk("t6_no_if_gnt", bus.mem_req, 0);
        bus.dm_req = 0;
        bus.mem_rdata = 32'h00000013;
        tick();
        chk("t6_if_req", bus.mem_req, 1);
        chk("t6_if_addr", bus.mem_addr, 32'h30);
        chk("t6_if_size", bus.mem_size, 32'(SIZE_WORD));
        tick();
        chk("t6_if_done", bus.if_done, 1);
        chk("t6_if_rdata", bus.if_rdata, 32'h00000013);
        bus.if_req = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
